// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller slice.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: bus widths, memory function/type codes, FSM state encoding,
//           access-size decode helper and byte-to-word address helper.
package dmem_ctrl_pkg;

    localparam int RV_BIT_NUM      = 32;
    localparam int MEM_FCN_BIT_NUM = 1;
    localparam int MEM_TYP_BIT_NUM = 3;

    localparam logic [MEM_FCN_BIT_NUM-1:0] M_XRD = 1'b0;
    localparam logic [MEM_FCN_BIT_NUM-1:0] M_XWR = 1'b1;

    localparam logic [MEM_TYP_BIT_NUM-1:0] MT_B  = 3'd1;
    localparam logic [MEM_TYP_BIT_NUM-1:0] MT_H  = 3'd2;
    localparam logic [MEM_TYP_BIT_NUM-1:0] MT_W  = 3'd3;
    localparam logic [MEM_TYP_BIT_NUM-1:0] MT_BU = 3'd5;
    localparam logic [MEM_TYP_BIT_NUM-1:0] MT_HU = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } ctrlStateT;

    typedef enum logic [1:0] {
        ACC_B = 2'd0,
        ACC_H = 2'd1,
        ACC_W = 2'd2
    } accSizeT;

    // Signed and unsigned variants share a size; unknown codes act as a word.
    function automatic accSizeT accessSize(input logic [MEM_TYP_BIT_NUM-1:0] typ);
        case (typ)
            MT_B, MT_BU: return ACC_B;
            MT_H, MT_HU: return ACC_H;
            default:     return ACC_W;
        endcase
    endfunction

    function automatic logic [RV_BIT_NUM-1:0] byteToWord(
        input logic [RV_BIT_NUM-1:0] addr,
        input logic [RV_BIT_NUM-1:0] base
    );
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core load/store request bus plus host back-door write port.
// Latency: none (wires only).
// Backpressure: dmem_req_ready gates core requests; the back-door has none.
// master: core/host side drives requests and back-door writes.
// slave:  dmem_ctrl drives ready, response pulse, load data and error.
interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    logic                       dmem_valid;
    logic [MEM_FCN_BIT_NUM-1:0] dmem_fcn;
    logic [MEM_TYP_BIT_NUM-1:0] dmem_typ;
    logic [RV_BIT_NUM-1:0]      dmem_addr;
    logic [RV_BIT_NUM-1:0]      dmem_data_i;
    logic                       dmem_req_ready;
    logic                       dmem_resp_valid;
    logic [RV_BIT_NUM-1:0]      dmem_data_o;
    logic                       dmem_resp_err;
    logic                       dmem_wr_valid;
    logic [RV_BIT_NUM-1:0]      dmem_wr_addr;
    logic [RV_BIT_NUM-1:0]      dmem_wr_data;

    modport master (
        output dmem_valid, dmem_fcn, dmem_typ, dmem_addr, dmem_data_i,
        output dmem_wr_valid, dmem_wr_addr, dmem_wr_data,
        input  dmem_req_ready, dmem_resp_valid, dmem_data_o, dmem_resp_err
    );

    modport slave (
        input  dmem_valid, dmem_fcn, dmem_typ, dmem_addr, dmem_data_i,
        input  dmem_wr_valid, dmem_wr_addr, dmem_wr_data,
        output dmem_req_ready, dmem_resp_valid, dmem_data_o, dmem_resp_err
    );

endinterface

// File: rtl/dmem_ctrl_ram.sv
// Single-port word RAM with byte write enables plus a full-word back-door write port.
// Latency: registered read, data one cycle after rdEn.
// Backpressure: none; accepts a read or write every cycle.
// Ports: clk; rdEn/byteWe/addr/wrData/rdData core port; bdWe/bdAddr/bdData back-door.
module dmem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rdEn,
    input  logic [3:0]        byteWe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wrData,
    output logic [31:0]       rdData,
    input  logic              bdWe,
    input  logic [ADDR_W-1:0] bdAddr,
    input  logic [31:0]       bdData
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Back-door write is issued first so that core byte lanes to the same
    // word override it, while uncovered lanes keep the back-door data.
    // Reads see the pre-write contents (no forwarding).
    always_ff @(posedge clk) begin
        if (bdWe) begin
            mem[bdAddr] <= bdData;
        end
        for (int i = 0; i < 4; i++) begin
            if (byteWe[i]) begin
                mem[addr][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
        if (rdEn) begin
            rdData <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: core load/store FSM, store lane merge, load extension.
// Latency: load response 2 cycles after accept, store response 1 cycle after accept.
// Backpressure: dmem_req_ready low outside IDLE, during reset, or while a back-door write is present.
// Ports: clk, rst (sync, active-high); dmem (dmem_ctrl_if.slave) carries the core
//        request/response and host back-door write signals.
// Build option: DMEM_MISALIGN_TRAP_EN flags misaligned half/word accesses with
//        dmem_resp_err instead of masking the low address bits.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    dmem_ctrl_if.slave dmem
);

    ctrlStateT state, stateNext;

    logic                       accept;
    logic [1:0]                 reqOff;
    accSizeT                    reqSize;
    logic [ADDR_W-1:0]          reqIdx;
    logic [ADDR_W-1:0]          bdIdx;

    // Request fields held for the duration of the access. The function code
    // is carried by the RD/WR state itself.
    logic [MEM_TYP_BIT_NUM-1:0] typQ;
    logic [1:0]                 offQ;
    logic [ADDR_W-1:0]          idxQ;
    logic [RV_BIT_NUM-1:0]      dataQ;

    logic [3:0]                 byteEn;
    logic [3:0]                 ramWe;
    logic [31:0]                wrWord;
    logic [31:0]                rdWord;
    logic [31:0]                shifted;
    logic [31:0]                loadWord;
    logic                       respValid;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic                       reqMis;
    logic                       misQ;
`endif

    assign reqSize = accessSize(dmem.dmem_typ);
    assign reqIdx  = ADDR_W'(byteToWord(dmem.dmem_addr, BASE_ADDR));
    assign bdIdx   = ADDR_W'(byteToWord(dmem.dmem_wr_addr, BASE_ADDR));

    assign dmem.dmem_req_ready = (state == IDLE) && !dmem.dmem_wr_valid && !rst;
    assign accept              = dmem.dmem_valid && dmem.dmem_req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign reqOff = dmem.dmem_addr[1:0];
    assign reqMis = ((reqSize == ACC_H) && dmem.dmem_addr[0]) ||
                    ((reqSize == ACC_W) && (dmem.dmem_addr[1:0] != 2'b00));
`else
    // Without trapping, misaligned halves/words are silently aligned down.
    always_comb begin
        reqOff = dmem.dmem_addr[1:0];
        case (reqSize)
            ACC_H:   reqOff[0] = 1'b0;
            ACC_W:   reqOff    = 2'b00;
            default: ;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            typQ  <= dmem.dmem_typ;
            offQ  <= reqOff;
            idxQ  <= reqIdx;
            dataQ <= dmem.dmem_data_i;
`ifdef DMEM_MISALIGN_TRAP_EN
            misQ  <= reqMis;
`endif
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = (dmem.dmem_fcn == M_XWR) ? WR : RD;
                end
            end
            RD:      stateNext = RESP;
            WR:      stateNext = IDLE;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Store lane merge: data is replicated across the word so the enabled
    // lanes always see the right bytes regardless of offset.
    always_comb begin
        byteEn = 4'b1111;
        wrWord = dataQ;
        case (accessSize(typQ))
            ACC_B: begin
                byteEn = 4'b0001 << offQ;
                wrWord = {4{dataQ[7:0]}};
            end
            ACC_H: begin
                byteEn = offQ[1] ? 4'b1100 : 4'b0011;
                wrWord = {2{dataQ[15:0]}};
            end
            default: ;
        endcase
    end

    // A store caught by reset in WR is abandoned, not written.
`ifdef DMEM_MISALIGN_TRAP_EN
    assign ramWe = ((state == WR) && !rst && !misQ) ? byteEn : 4'b0000;
`else
    assign ramWe = ((state == WR) && !rst) ? byteEn : 4'b0000;
`endif

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rdEn   (state == RD),
        .byteWe (ramWe),
        .addr   (idxQ),
        .wrData (wrWord),
        .rdData (rdWord),
        .bdWe   (dmem.dmem_wr_valid),
        .bdAddr (bdIdx),
        .bdData (dmem.dmem_wr_data)
    );

    assign shifted = rdWord >> {offQ, 3'b000};

    always_comb begin
        loadWord = shifted;
        case (typQ)
            MT_B:    loadWord = {{24{shifted[7]}}, shifted[7:0]};
            MT_BU:   loadWord = {24'h0, shifted[7:0]};
            MT_H:    loadWord = {{16{shifted[15]}}, shifted[15:0]};
            MT_HU:   loadWord = {16'h0, shifted[15:0]};
            default: loadWord = shifted;
        endcase
    end

    // Responses are gated by rst so a reset cycle never shows a pulse.
    assign respValid            = !rst && ((state == RESP) || (state == WR));
    assign dmem.dmem_resp_valid = respValid;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign dmem.dmem_data_o   = (!rst && (state == RESP) && !misQ) ? loadWord : 32'h0;
    assign dmem.dmem_resp_err = respValid && misQ;
`else
    assign dmem.dmem_data_o   = (!rst && (state == RESP)) ? loadWord : 32'h0;
    assign dmem.dmem_resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int          AW    = 12;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if dif();

    dmem_ctrl #(
        .ADDR_W    (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dmem (dif)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          isLoad;
        logic [31:0] data;
        logic        err;
    } expT;
    expT sb[$];

    logic [31:0] refMem [DEPTH];
    logic [2:0]  typs [5] = '{MT_B, MT_H, MT_W, MT_BU, MT_HU};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-level view of memory) -------
    function automatic int szOf(logic [2:0] t);
        case (t)
            MT_B, MT_BU: return 1;
            MT_H, MT_HU: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic int idxOf(logic [31:0] a);
        return int'(((a - BASE) >> 2) % DEPTH);
    endfunction

    function automatic bit isMis(logic [2:0] t, logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (int'(a[1:0]) % szOf(t)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelStore(logic [2:0] t, logic [31:0] a, logic [31:0] d, output logic err);
        int sz  = szOf(t);
        int idx = idxOf(a);
        int off = int'(a[1:0]);
        err = isMis(t, a);
        if (!err) begin
            off = off - (off % sz);
            for (int k = 0; k < sz; k++) refMem[idx][8*(off+k) +: 8] = d[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] modelLoad(logic [2:0] t, logic [31:0] a, output logic err);
        int          sz  = szOf(t);
        int          idx = idxOf(a);
        int          off = int'(a[1:0]);
        logic [31:0] v   = 32'h0;
        err = isMis(t, a);
        if (err) return 32'h0;
        off = off - (off % sz);
        for (int k = 0; k < sz; k++) v[8*k +: 8] = refMem[idx][8*(off+k) +: 8];
        if (sz < 4 && (t == MT_B || t == MT_H) && v[8*sz-1])
            for (int b = 8*sz; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    // ---------------- monitor -----------------------------------------
    always @(negedge clk) begin
        expT e;
        if (dif.dmem_resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                if (e.isLoad) chk("load_data", dif.dmem_data_o, e.data);
                chk("resp_err", {31'h0, dif.dmem_resp_err}, {31'h0, e.err});
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_resp: resp_valid=0 at cycle %0d, expected 1", e.cyc);
        end
    end

    // ---------------- stimulus tasks (enter/leave just after posedge) ---
    task automatic bd(logic [31:0] a, logic [31:0] d);
        dif.dmem_wr_valid = 1'b1;
        dif.dmem_wr_addr  = a;
        dif.dmem_wr_data  = d;
        refMem[idxOf(a)]  = d;
        @(posedge clk); #1;
        dif.dmem_wr_valid = 1'b0;
    endtask

    task automatic coreReq(logic fcn, logic [2:0] t, logic [31:0] a, logic [31:0] d,
                           bit useExp, logic [31:0] expv);
        int          waitCnt = 0;
        bit          ok      = 0;
        logic        err;
        logic [31:0] v;
        dif.dmem_valid  = 1'b1;
        dif.dmem_fcn    = fcn;
        dif.dmem_typ    = t;
        dif.dmem_addr   = a;
        dif.dmem_data_i = d;
        while (!ok && waitCnt < 20) begin
            @(negedge clk);
            if (dif.dmem_req_ready === 1'b1) ok = 1;
            else begin
                @(posedge clk); #1;
                waitCnt++;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready=0 for 20 cycles, expected 1");
            dif.dmem_valid = 1'b0;
            return;
        end
        if (fcn == M_XWR) begin
            modelStore(t, a, d, err);
            sb.push_back('{cyc: cyc + 1, isLoad: 0, data: 32'h0, err: err});
        end else begin
            v = modelLoad(t, a, err);
            sb.push_back('{cyc: cyc + 2, isLoad: 1, data: useExp ? expv : v, err: err});
        end
        @(posedge clk); #1;
        dif.dmem_valid = 1'b0;
        @(negedge clk);
        chk("busy_ready1", {31'h0, dif.dmem_req_ready}, 32'h0);
        if (fcn == M_XRD) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("busy_ready2", {31'h0, dif.dmem_req_ready}, 32'h0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          op;
        dif.dmem_valid    = 1'b0;
        dif.dmem_fcn      = M_XRD;
        dif.dmem_typ      = MT_W;
        dif.dmem_addr     = 32'h0;
        dif.dmem_data_i   = 32'h0;
        dif.dmem_wr_valid = 1'b0;
        dif.dmem_wr_addr  = 32'h0;
        dif.dmem_wr_data  = 32'h0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, dif.dmem_req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, dif.dmem_resp_valid}, 32'h0);
        chk("rst_data_o", dif.dmem_data_o, 32'h0);
        chk("rst_resp_err", {31'h0, dif.dmem_resp_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Preload every word so the RAM holds defined values
        for (int i = 0; i < DEPTH; i++) bd(BASE + 32'(i) * 4, $urandom);

        // Word load latency
        bd(32'h10, 32'hDEADBEEF);
        coreReq(M_XRD, MT_W, 32'h10, 0, 1, 32'hDEADBEEF);

        // Load extraction
        bd(32'h20, 32'h80FF7F01);
        coreReq(M_XRD, MT_B,  32'h21, 0, 1, 32'h0000007F);
        coreReq(M_XRD, MT_B,  32'h23, 0, 1, 32'hFFFFFF80);
        coreReq(M_XRD, MT_BU, 32'h22, 0, 1, 32'h000000FF);
        coreReq(M_XRD, MT_H,  32'h22, 0, 1, 32'hFFFF80FF);

        // Sub-word store merge
        bd(32'h30, 32'h11223344);
        coreReq(M_XWR, MT_B, 32'h31, 32'h000000AA, 0, 0);
        coreReq(M_XWR, MT_H, 32'h32, 32'h0000BBCC, 0, 0);
        coreReq(M_XRD, MT_W, 32'h30, 0, 1, 32'hBBCCAA44);

        // Core request and back-door together in IDLE
        dif.dmem_valid    = 1'b1;
        dif.dmem_fcn      = M_XRD;
        dif.dmem_typ      = MT_W;
        dif.dmem_addr     = 32'h40;
        dif.dmem_wr_valid = 1'b1;
        dif.dmem_wr_addr  = 32'h40;
        dif.dmem_wr_data  = 32'h12345678;
        refMem[idxOf(32'h40)] = 32'h12345678;
        @(negedge clk);
        chk("sim_ready_blocked", {31'h0, dif.dmem_req_ready}, 32'h0);
        @(posedge clk); #1;
        dif.dmem_wr_valid = 1'b0;
        @(negedge clk);
        chk("sim_ready_next", {31'h0, dif.dmem_req_ready}, 32'h1);
        sb.push_back('{cyc: cyc + 2, isLoad: 1, data: 32'h12345678, err: 1'b0});
        @(posedge clk); #1;
        dif.dmem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while in RD drops the response
        dif.dmem_valid = 1'b1;
        dif.dmem_fcn   = M_XRD;
        dif.dmem_typ   = MT_W;
        dif.dmem_addr  = 32'h10;
        @(negedge clk);
        chk("rst_rd_accept", {31'h0, dif.dmem_req_ready}, 32'h1);
        @(posedge clk); #1;
        dif.dmem_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd_no_resp", {31'h0, dif.dmem_resp_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_resp", {31'h0, dif.dmem_resp_valid}, 32'h0);
        chk("rst_after_data", dif.dmem_data_o, 32'h0);
        chk("rst_after_err", {31'h0, dif.dmem_resp_err}, 32'h0);
        chk("rst_after_ready", {31'h0, dif.dmem_req_ready}, 32'h1);
        @(posedge clk); #1;
        coreReq(M_XRD, MT_W, 32'h10, 0, 1, 32'hDEADBEEF);

        // Misaligned word store
        bd(32'h30, 32'h01020304);
        coreReq(M_XWR, MT_W, 32'h32, 32'hCAFEF00D, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        coreReq(M_XRD, MT_W, 32'h30, 0, 1, 32'h01020304);
`else
        coreReq(M_XRD, MT_W, 32'h30, 0, 1, 32'hCAFEF00D);
`endif

        // Back-door colliding with a core store in WR: core lanes win
        bd(32'h50, 32'h0);
        dif.dmem_valid  = 1'b1;
        dif.dmem_fcn    = M_XWR;
        dif.dmem_typ    = MT_B;
        dif.dmem_addr   = 32'h51;
        dif.dmem_data_i = 32'h000000EE;
        @(negedge clk);
        chk("col_accept", {31'h0, dif.dmem_req_ready}, 32'h1);
        sb.push_back('{cyc: cyc + 1, isLoad: 0, data: 32'h0, err: 1'b0});
        @(posedge clk); #1;
        dif.dmem_valid = 1'b0;
        bd(32'h50, 32'hA1B2C3D4);
        begin
            logic e0;
            modelStore(MT_B, 32'h51, 32'h000000EE, e0);
        end
        coreReq(M_XRD, MT_W, 32'h50, 0, 1, 32'hA1B2EED4);

        // Back-door during RD does not forward
        bd(32'h60, 32'h11111111);
        dif.dmem_valid = 1'b1;
        dif.dmem_fcn   = M_XRD;
        dif.dmem_typ   = MT_W;
        dif.dmem_addr  = 32'h60;
        @(negedge clk);
        chk("rdfwd_accept", {31'h0, dif.dmem_req_ready}, 32'h1);
        sb.push_back('{cyc: cyc + 2, isLoad: 1, data: 32'h11111111, err: 1'b0});
        @(posedge clk); #1;
        dif.dmem_valid = 1'b0;
        bd(32'h60, 32'h22222222);
        @(posedge clk); #1;
        coreReq(M_XRD, MT_W, 32'h60, 0, 1, 32'h22222222);

        // Address wrap: 2^AW words above 0x70 aliases 0x70
        coreReq(M_XWR, MT_W, 32'h70 + 32'(DEPTH) * 4, 32'h5A5AA5A5, 0, 0);
        coreReq(M_XRD, MT_W, 32'h70, 0, 1, 32'h5A5AA5A5);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a = $urandom & 32'h0000_FFFF;
            else a = 32'h100 + 32'($urandom_range(0, 31));
            if (op < 2) bd(a & 32'hFFFF_FFFC, $urandom);
            else if (op < 6) coreReq(M_XWR, typs[$urandom_range(0, 4)], a, $urandom, 0, 0);
            else coreReq(M_XRD, typs[$urandom_range(0, 4)], a, 0, 0, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
